// File: rtl/elc_defs.sv
`default_nettype none
// ============================================================================
//  Module      : elc_defs (package)
//  Description : Shared definitions for the door actuator controller: FSM
//                state encodings, default parameter values and a helper
//                that sizes the shared down-timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package elc_defs;

    // Default parameter values for door_actuator_ctrl
    localparam int c_def_unlock_cycles = 8;
    localparam int c_def_open_limit    = 16;
    localparam int c_def_err_limit     = 3;
    localparam int c_def_beep_cycles   = 4;

    // FSM state encodings (visible on the state output port)
    typedef enum logic [2:0] {
        ST_LOCKED   = 3'd0,
        ST_RELEASED = 3'd1,
        ST_OPEN     = 3'd2,
        ST_HELD     = 3'd3,
        ST_FORCED   = 3'd4
    } elc_state_e;

    // Timer width: clog2 of the larger of the two load lengths, never below 1
    function automatic int elc_timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return ($clog2(m) > 0) ? $clog2(m) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elc_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : elc_down_timer
//  Description : Loadable down-counter that holds at zero (no wrap) and flags
//                when it has reached zero. Shared by RELEASED and OPEN.
//  Revision    : 1.0 - initial release
// ============================================================================
module elc_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: a load wins, otherwise decrement and hold at zero
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register, cleared by the asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/door_actuator_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : door_actuator_ctrl
//  Description : Door latch actuator controller. Releases the latch on an
//                unlock edge, supervises how long the door stays open, latches
//                a forced-entry alarm and sounds a warning beep after a run of
//                lock-controller errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module door_actuator_ctrl
    import elc_defs::*;
#(
    parameter int UNLOCK_CYCLES = c_def_unlock_cycles,
    parameter int OPEN_LIMIT    = c_def_open_limit,
    parameter int ERR_LIMIT     = c_def_err_limit,
    parameter int BEEP_CYCLES   = c_def_beep_cycles
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       unlock,
    input  logic       error,
    input  logic       card_is_needed,
    input  logic       door_closed,
    input  logic       alarm_clr,
    output logic       latch_release,
    output logic       alarm,
    output logic       warn_beep,
    output logic       card_prompt,
    output logic [2:0] state
);

    localparam int c_timer_w = elc_timer_width(UNLOCK_CYCLES, OPEN_LIMIT);
    localparam int c_err_w   = $clog2(ERR_LIMIT + 1);
    localparam int c_beep_w  = $clog2(BEEP_CYCLES + 1);

    localparam logic [c_timer_w-1:0] c_unlock_load = c_timer_w'(UNLOCK_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_open_load   = c_timer_w'(OPEN_LIMIT - 1);
    localparam logic [c_err_w-1:0]   c_err_last    = c_err_w'(ERR_LIMIT - 1);
    localparam logic [c_beep_w-1:0]  c_beep_len    = c_beep_w'(BEEP_CYCLES);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic dc_meta_q;
    logic dc_s_q;
    logic unlock_q;
    logic error_q;
    logic card_prompt_q;

    // Door sensor synchronizer (idles "closed"), edge-detect delays, card prompt delay
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dc_meta_q     <= 1'b1;
            dc_s_q        <= 1'b1;
            unlock_q      <= 1'b0;
            error_q       <= 1'b0;
            card_prompt_q <= 1'b0;
        end else begin
            dc_meta_q     <= door_closed;
            dc_s_q        <= dc_meta_q;
            unlock_q      <= unlock;
            error_q       <= error;
            card_prompt_q <= card_is_needed;
        end
    end

    logic w_unlock_edge;
    logic w_error_edge;

    assign w_unlock_edge = unlock & ~unlock_q;
    assign w_error_edge  = error & ~error_q;

    // ------------------------------------------------------------------
    // Shared down-timer
    // ------------------------------------------------------------------
    logic                 w_tmr_load;
    logic [c_timer_w-1:0] w_tmr_val;
    logic                 w_tmr_zero;

    elc_down_timer #(
        .WIDTH    (c_timer_w)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .zero     (w_tmr_zero)
    );

    // ------------------------------------------------------------------
    // Door FSM
    // ------------------------------------------------------------------
    elc_state_e state_q;
    elc_state_e state_d;
    logic       latch_release_q;
    logic       latch_release_d;
    logic       alarm_q;
    logic       alarm_d;

    // Next-state, timer load and Moore output decode of the next state
    always_comb begin
        state_d    = state_q;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (state_q)
            ST_LOCKED: begin
                // A door opening without release takes priority over unlock
                if (!dc_s_q) begin
                    state_d = ST_FORCED;
                end else if (w_unlock_edge) begin
                    state_d    = ST_RELEASED;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_unlock_load;
                end
            end
            ST_RELEASED: begin
                // Further unlock edges are ignored here: no timer reload
                if (!dc_s_q) begin
                    state_d    = ST_OPEN;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_open_load;
                end else if (w_tmr_zero) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_OPEN: begin
                if (dc_s_q) begin
                    state_d = ST_LOCKED;
                end else if (w_tmr_zero) begin
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (dc_s_q) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_FORCED: begin
                // Acknowledge only counts once the door is shut again
                if (alarm_clr && dc_s_q) begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_LOCKED;
            end
        endcase
        latch_release_d = (state_d == ST_RELEASED);
        alarm_d         = (state_d == ST_HELD) || (state_d == ST_FORCED);
    end

    // State register with registered Moore outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_LOCKED;
            latch_release_q <= 1'b0;
            alarm_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            latch_release_q <= latch_release_d;
            alarm_q         <= alarm_d;
        end
    end

    // ------------------------------------------------------------------
    // Error counter and warning beep
    // ------------------------------------------------------------------
    logic [c_err_w-1:0]  err_cnt_q;
    logic [c_err_w-1:0]  err_cnt_d;
    logic [c_beep_w-1:0] beep_cnt_q;
    logic [c_beep_w-1:0] beep_cnt_d;
    logic                warn_beep_q;
    logic                warn_beep_d;

    // Count error edges; the unlock clear wins; reaching the limit fires a beep
    always_comb begin
        err_cnt_d  = err_cnt_q;
        beep_cnt_d = beep_cnt_q;
        if (beep_cnt_q != '0) begin
            beep_cnt_d = beep_cnt_q - 1'b1;
        end
        if (w_unlock_edge) begin
            err_cnt_d = '0;
        end else if (w_error_edge) begin
            if (err_cnt_q >= c_err_last) begin
                err_cnt_d = '0;
                // A beep already sounding is neither restarted nor extended
                if (beep_cnt_q == '0) begin
                    beep_cnt_d = c_beep_len;
                end
            end else begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
        warn_beep_d = (beep_cnt_d != '0);
    end

    // Error count, beep length counter and registered beep output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q   <= '0;
            beep_cnt_q  <= '0;
            warn_beep_q <= 1'b0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            beep_cnt_q  <= beep_cnt_d;
            warn_beep_q <= warn_beep_d;
        end
    end

    assign latch_release = latch_release_q;
    assign alarm         = alarm_q;
    assign warn_beep     = warn_beep_q;
    assign card_prompt   = card_prompt_q;
    assign state         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_door_actuator_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_door_actuator_ctrl
//  Description : Directed bench for door_actuator_ctrl. Stimulus pushes the
//                hand-computed expected outputs for given cycles into a
//                queue; a monitor pops and compares them on falling edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_door_actuator_ctrl;

    localparam logic [2:0] c_locked   = 3'd0;
    localparam logic [2:0] c_released = 3'd1;
    localparam logic [2:0] c_open     = 3'd2;
    localparam logic [2:0] c_held     = 3'd3;
    localparam logic [2:0] c_forced   = 3'd4;

    logic       clk = 1'b0;
    logic       reset;
    logic       unlock;
    logic       error;
    logic       card_is_needed;
    logic       door_closed;
    logic       alarm_clr;
    logic       latch_release;
    logic       alarm;
    logic       warn_beep;
    logic       card_prompt;
    logic [2:0] state;

    door_actuator_ctrl #(
        .UNLOCK_CYCLES  (8),
        .OPEN_LIMIT     (16),
        .ERR_LIMIT      (3),
        .BEEP_CYCLES    (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .unlock         (unlock),
        .error          (error),
        .card_is_needed (card_is_needed),
        .door_closed    (door_closed),
        .alarm_clr      (alarm_clr),
        .latch_release  (latch_release),
        .alarm          (alarm),
        .warn_beep      (warn_beep),
        .card_prompt    (card_prompt),
        .state          (state)
    );

    always #5 clk = ~clk;

    // Cycle index: number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       latch;
        logic       alm;
        logic       beep;
        logic       prompt;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   b     = 0;

    // Queue an expectation for cycle b+k
    task automatic exp_at(input int k, input logic [2:0] st, input logic l,
                          input logic a, input logic bp, input logic p,
                          input string nm);
        exp_t e;
        e.cyc    = b + k;
        e.st     = st;
        e.latch  = l;
        e.alm    = a;
        e.beep   = bp;
        e.prompt = p;
        e.name   = nm;
        sb.push_back(e);
    endtask

    // Advance to 1 time unit after rising edge number b+k
    task automatic at(input int k);
        while (cyc < b + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every expectation due in the current cycle
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                n_vec++;
                if (e.cyc != cyc || state !== e.st || latch_release !== e.latch ||
                    alarm !== e.alm || warn_beep !== e.beep || card_prompt !== e.prompt) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d: got state=%0d latch=%b alarm=%b beep=%b prompt=%b, expected state=%0d latch=%b alarm=%b beep=%b prompt=%b (due cyc %0d)",
                             e.name, cyc, state, latch_release, alarm, warn_beep, card_prompt,
                             e.st, e.latch, e.alm, e.beep, e.prompt, e.cyc);
                end
            end
        end
    end

    initial begin
        reset          = 1'b0;
        unlock         = 1'b0;
        error          = 1'b0;
        card_is_needed = 1'b0;
        door_closed    = 1'b1;
        alarm_clr      = 1'b0;

        // Reset state and release
        repeat (2) @(posedge clk);
        #1;
        b = cyc;
        exp_at(0, c_locked, 0, 0, 0, 0, "reset_state");
        exp_at(2, c_locked, 0, 0, 0, 0, "after_reset_release");
        at(1); reset = 1'b1;
        at(4);

        // Single unlock pulse, door stays closed; second unlock ignored
        b = cyc;
        exp_at(1,  c_released, 1, 0, 0, 0, "t1_released_first");
        exp_at(8,  c_released, 1, 0, 0, 0, "t1_released_last");
        exp_at(9,  c_locked,   0, 0, 0, 0, "t1_relock");
        exp_at(12, c_locked,   0, 0, 0, 0, "t1_stay_locked");
        at(0); unlock = 1'b1;
        at(1); unlock = 1'b0;
        at(3); unlock = 1'b1;
        at(4); unlock = 1'b0;
        at(13);

        // Normal passage: open on cycle 3, close 5 cycles later
        b = cyc;
        exp_at(1,  c_released, 1, 0, 0, 0, "t2_released");
        exp_at(5,  c_released, 1, 0, 0, 0, "t2_before_open");
        exp_at(6,  c_open,     0, 0, 0, 0, "t2_open");
        exp_at(10, c_open,     0, 0, 0, 0, "t2_still_open");
        exp_at(11, c_locked,   0, 0, 0, 0, "t2_closed");
        at(0); unlock = 1'b1;
        at(1); unlock = 1'b0;
        at(3); door_closed = 1'b0;
        at(8); door_closed = 1'b1;
        at(13);

        // Door held open past the limit
        b = cyc;
        exp_at(1,  c_released, 1, 0, 0, 0, "t3_released");
        exp_at(4,  c_released, 1, 0, 0, 0, "t3_before_open");
        exp_at(5,  c_open,     0, 0, 0, 0, "t3_open");
        exp_at(20, c_open,     0, 0, 0, 0, "t3_open_last");
        exp_at(21, c_held,     0, 1, 0, 0, "t3_held");
        exp_at(24, c_held,     0, 1, 0, 0, "t3_held_closing");
        exp_at(25, c_locked,   0, 0, 0, 0, "t3_closed");
        at(0);  unlock = 1'b1;
        at(1);  unlock = 1'b0;
        at(2);  door_closed = 1'b0;
        at(22); door_closed = 1'b1;
        at(27);

        // Forced entry (coincident unlock loses), clear only with door shut
        b = cyc;
        exp_at(2,  c_locked, 0, 0, 0, 0, "t4_locked_pre");
        exp_at(3,  c_forced, 0, 1, 0, 0, "t4_forced_wins");
        exp_at(5,  c_forced, 0, 1, 0, 0, "t4_clr_while_open");
        exp_at(6,  c_forced, 0, 1, 0, 0, "t4_still_forced");
        exp_at(10, c_forced, 0, 1, 0, 0, "t4_closed_no_clr");
        exp_at(11, c_forced, 0, 1, 0, 0, "t4_before_clr");
        exp_at(12, c_locked, 0, 0, 0, 0, "t4_cleared");
        at(0);  door_closed = 1'b0;
        at(2);  unlock = 1'b1;
        at(3);  unlock = 1'b0;
        at(4);  alarm_clr = 1'b1;
        at(5);  alarm_clr = 1'b0;
        at(7);  door_closed = 1'b1;
        at(11); alarm_clr = 1'b1;
        at(12); alarm_clr = 1'b0;
        at(15);

        // Error counting, unlock clear, clear-wins and no-retrigger
        b = cyc;
        exp_at(13,  c_locked,   0, 0, 0, 0, "t5_two_errors");
        exp_at(24,  c_locked,   0, 0, 0, 0, "t5_before_third");
        exp_at(25,  c_locked,   0, 0, 1, 0, "t5_beep_start");
        exp_at(28,  c_locked,   0, 0, 1, 0, "t5_beep_last");
        exp_at(29,  c_locked,   0, 0, 0, 0, "t5_beep_end");
        exp_at(53,  c_released, 1, 0, 0, 0, "t5_unlock_cleared");
        exp_at(54,  c_released, 1, 0, 0, 0, "t5_unlock_cleared2");
        exp_at(57,  c_locked,   0, 0, 0, 0, "t5_relocked");
        exp_at(69,  c_released, 1, 0, 0, 0, "t5_clear_wins");
        exp_at(70,  c_released, 1, 0, 0, 0, "t5_clear_wins2");
        exp_at(77,  c_locked,   0, 0, 0, 0, "t5_relocked2");
        exp_at(85,  c_locked,   0, 0, 0, 0, "t5_count_two");
        exp_at(86,  c_locked,   0, 0, 0, 0, "t5_count_two_b");
        exp_at(89,  c_locked,   0, 0, 1, 0, "t5_beep2_start");
        exp_at(92,  c_locked,   0, 0, 1, 0, "t5_beep2_last");
        exp_at(93,  c_locked,   0, 0, 0, 0, "t5_no_extend");
        exp_at(104, c_locked,   0, 0, 0, 0, "t5_before_beep3");
        exp_at(105, c_locked,   0, 0, 1, 0, "t5_beep3_start");
        for (int k = 0; k < 110; k++) begin
            at(k);
            error  = (k inside {0, 12, 24, 40, 44, 52, 60, 64, 68, 80, 84, 88, 90, 100, 104});
            unlock = (k inside {48, 68});
        end
        at(110);

        // Reset while OPEN with two errors counted
        b = cyc;
        exp_at(7,  c_open,   0, 0, 0, 1, "t6_open_prompt");
        exp_at(9,  c_locked, 0, 0, 0, 0, "t6_reset_async");
        exp_at(10, c_locked, 0, 0, 0, 0, "t6_in_reset");
        exp_at(12, c_locked, 0, 0, 0, 1, "t6_prompt_after_reset");
        exp_at(13, c_locked, 0, 0, 0, 0, "t6_prompt_drop");
        exp_at(15, c_locked, 0, 0, 0, 0, "t6_err_no_beep");
        exp_at(16, c_locked, 0, 0, 0, 0, "t6_err_no_beep2");
        exp_at(17, c_locked, 0, 0, 0, 0, "t6_err_no_beep3");
        at(0);  unlock = 1'b1;
        at(1);  unlock = 1'b0;
        at(2);  error = 1'b1;
        at(3);  error = 1'b0; door_closed = 1'b0;
        at(4);  error = 1'b1;
        at(5);  error = 1'b0;
        at(6);  card_is_needed = 1'b1;
        at(9);  reset = 1'b0; door_closed = 1'b1;
        at(11); reset = 1'b1;
        at(12); card_is_needed = 1'b0;
        at(14); error = 1'b1;
        at(15); error = 1'b0;
        at(19);

        // Drain the scoreboard with a bounded wait
        begin
            int guard;
            guard = 0;
            while (sb.size() > 0 && guard < 50) begin
                @(posedge clk);
                guard++;
            end
            if (sb.size() > 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/door_actuator_ctrl.md
DOOR_ACTUATOR_CTRL -- requirements
Module: door_actuator_ctrl

Interface
REQ-001 SHALL have parameter UNLOCK_CYCLES, default 8: number of cycles the latch is released.
REQ-002 SHALL have parameter OPEN_LIMIT, default 16: maximum cycles the door may stay open before the alarm sounds.
REQ-003 SHALL have parameter ERR_LIMIT, default 3: number of consecutive errors that triggers the warning beep.
REQ-004 SHALL have parameter BEEP_CYCLES, default 4: length of the warn_beep pulse in cycles.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port unlock, input, 1 bit: level from the upstream lock controller.
REQ-008 SHALL have port error, input, 1 bit: level from the lock controller.
REQ-009 SHALL have port card_is_needed, input, 1 bit: level from the lock controller.
REQ-010 SHALL have port door_closed, input, 1 bit: asynchronous door sensor, 1 = closed.
REQ-011 SHALL have port alarm_clr, input, 1 bit: synchronous acknowledge for the forced-entry alarm.
REQ-012 SHALL have port latch_release, output, 1 bit: drives the solenoid.
REQ-013 SHALL have port alarm, output, 1 bit.
REQ-014 SHALL have port warn_beep, output, 1 bit.
REQ-015 SHALL have port card_prompt, output, 1 bit: card_is_needed delayed by one register.
REQ-016 SHALL have port state, output, 3 bits: current FSM state encoding.

Function
REQ-017 door_closed SHALL pass through a 2-flop synchronizer; the FSM uses only the synchronized value (dc_s).
REQ-018 Each of unlock and error SHALL be registered once; the edge is detected as x & ~x_d.
REQ-019 FSM states SHALL be LOCKED=0, RELEASED=1, OPEN=2, HELD=3, FORCED=4; outputs are Moore-decoded from state.
REQ-020 LOCKED: unlock edge -> RELEASED and load timer with UNLOCK_CYCLES-1; dc_s=0 -> FORCED; if both occur in the same cycle, FORCED wins.
REQ-021 RELEASED: latch_release=1; dc_s=0 -> OPEN and load timer with OPEN_LIMIT-1; timer==0 with door closed -> LOCKED; latch_release therefore stays high exactly UNLOCK_CYCLES cycles.
REQ-022 RELEASED: a further unlock edge SHALL be ignored (no timer reload).
REQ-023 OPEN: latch_release=0; dc_s=1 -> LOCKED; timer==0 while open -> HELD.
REQ-024 HELD: alarm=1; dc_s=1 -> LOCKED, which clears the alarm.
REQ-025 FORCED: alarm=1 and stays latched; exits to LOCKED only when alarm_clr=1 and dc_s=1 in the same cycle; alarm_clr while the door is open has no effect.
REQ-026 Error counter SHALL count error edges, saturating at ERR_LIMIT.
REQ-027 When the error count reaches ERR_LIMIT, warn_beep SHALL go high for exactly BEEP_CYCLES cycles, starting the cycle after the counting edge, and the count SHALL reset to 0.
REQ-028 An unlock edge SHALL reset the error count to 0; if error and unlock edges coincide, the clear wins.
REQ-029 An error edge during an active beep SHALL count but SHALL NOT retrigger or extend the beep.
REQ-030 Timer width SHALL be $clog2(max(UNLOCK_CYCLES,OPEN_LIMIT)); the timer decrements and holds at 0 with no wrap.

Reset
REQ-031 On reset low, asynchronously: state=LOCKED, timer=0, error count=0, beep counter=0, synchronizer flops=1 (closed), edge registers=0, card_prompt=0, and all outputs 0.
REQ-032 Reset mid-operation (including FORCED) SHALL return the block to LOCKED; the alarm latch does not survive reset.
REQ-033 Deassertion of reset SHALL take effect at the next rising edge of clk; the first unlock edge is detectable one cycle later.

Structure
REQ-034 State encodings and the default parameter values SHALL live in the shared definitions package elc_defs.
REQ-035 The timer SHALL be a sub-module elc_down_timer with ports load, load_val, and zero, instantiated once and shared by RELEASED and OPEN.
REQ-036 Estimated size: about 200 RTL lines.

Verification
REQ-037 Unlock pulse of 1 cycle with the door kept closed -> latch_release high 8 cycles, then LOCKED, alarm=0.
REQ-038 Unlock, then door opens on cycle 3 and closes 5 cycles later -> states RELEASED, OPEN, LOCKED; latch_release drops when dc_s=0; alarm never set.
REQ-039 Unlock, then door opens and stays open 20 cycles -> HELD after 16 cycles in OPEN with alarm=1; closing the door -> LOCKED, alarm=0.
REQ-040 Door opens while LOCKED -> FORCED, alarm=1; alarm_clr while open -> no change; door closes plus alarm_clr -> LOCKED.
REQ-041 Three error pulses 12 cycles apart -> warn_beep high 4 cycles after the third; two errors then unlock then one error -> no beep.
REQ-042 Reset asserted while in OPEN with 2 errors counted -> immediately LOCKED, outputs 0; one subsequent error -> no beep.
